map_bram_arbiter: RTL and testbench
===================================

MAP_BRAM_ARBITER -- requirements
Module: map_bram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, SHALL set the map BRAM address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the tile-id data width.
REQ-003 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive denied cycles after which the game port wins; legal range 1..15.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-006 r_req  in  1  SHALL be the render port read request; held with r_addr until granted.
REQ-007 r_addr  in  ADDR_W  SHALL be the render read address.
REQ-008 r_gnt  out  1  SHALL be the combinational render grant, accepting the request this cycle.
REQ-009 r_rdata  out  DATA_W  SHALL be the registered render read data.
REQ-010 r_rvalid  out  1  SHALL be a one-cycle pulse marking r_rdata valid.
REQ-011 g_req  in  1  SHALL be the game-logic port request; held with g_we, g_addr and g_wdata until granted.
REQ-012 g_we  in  1  SHALL select write (1) or read (0) for the game request.
REQ-013 g_addr  in  ADDR_W  SHALL be the game address.
REQ-014 g_wdata  in  DATA_W  SHALL be the game write data (new tile id).
REQ-015 g_gnt  out  1  SHALL be the combinational game grant.
REQ-016 g_rdata  out  DATA_W  SHALL be the registered game read data.
REQ-017 g_rvalid  out  1  SHALL be a one-cycle pulse marking g_rdata valid; never pulses for writes.
REQ-018 bram_addr  out  ADDR_W  SHALL be the registered BRAM address.
REQ-019 bram_wr  out  1  SHALL be the registered BRAM write enable.
REQ-020 bram_dwrite  out  DATA_W  SHALL be the registered BRAM write data.
REQ-021 bram_data  in  DATA_W  SHALL be BRAM read data, valid one cycle after bram_addr is presented.

Function
REQ-022 At most one of r_gnt, g_gnt SHALL be high in any cycle; a grant is given only when the matching req is high.
REQ-023 Arbitration: render wins when both request, unless starve_cnt == STARVE_LIMIT, in which case game wins.
REQ-024 starve_cnt (4 bits) SHALL increment, saturating at STARVE_LIMIT, each cycle g_req is high and g_gnt low; clear to 0 on g_gnt or when g_req is low.
REQ-025 Accepted request in cycle N SHALL drive bram_addr (and bram_wr, bram_dwrite) in cycle N+1; bram_wr = 1 only for a granted game write, else 0.
REQ-026 When no grant occurs, bram_wr SHALL be 0 and bram_addr SHALL hold its previous value.
REQ-027 A 2-stage owner pipeline (render-read / game-read / none) SHALL track each issued access; bram_data in cycle N+2 is captured to the owner's rdata register, with rvalid high in cycle N+3.
REQ-028 Read latency SHALL be exactly 3 cycles from grant to rvalid; one access per cycle sustained throughput, back-to-back grants allowed.
REQ-029 A game write followed by any read of the same address SHALL return the written value, by serial ordering alone.
REQ-030 rdata registers SHALL hold their last value between rvalid pulses.
REQ-031 A requester dropping req without grant SHALL lose nothing; no state changes except starve_cnt clearing.

Reset
REQ-032 While rst is high: r_gnt = g_gnt = 0, regardless of requests.
REQ-033 On a clock edge with rst high: bram_addr = 0, bram_wr = 0, bram_dwrite = 0, r_rdata = g_rdata = 0, r_rvalid = g_rvalid = 0, starve_cnt = 0, owner pipeline = none.
REQ-034 Reads in flight at reset SHALL be discarded; no rvalid pulse for them after rst falls.

Verification
REQ-035 Game read only: g_req=1, g_we=0, g_addr=0x00107, BRAM[0x00107]=0x0023 -> g_gnt in cycle 0, bram_addr=0x00107 in cycle 1, g_rvalid with g_rdata=0x0023 in cycle 3, no r_rvalid.
REQ-036 Write then read: game write 0x0000 to 0x00107, next cycle render read 0x00107 -> bram_wr=1 for one cycle, r_rdata=0x0000 three cycles after r_gnt.
REQ-037 Starvation: r_req held high every cycle, g_req high from cycle 0, STARVE_LIMIT=4 -> r_gnt cycles 0-3, g_gnt in cycle 4, r_gnt resumes cycle 5.
REQ-038 Back-to-back: render reads 0x10, 0x11, 0x12 in consecutive cycles -> three consecutive r_rvalid pulses, data in address order.
REQ-039 Reset mid-flight: game read granted in cycle 0, rst high in cycle 1 -> g_rvalid never pulses; all outputs 0 in cycle 2.
REQ-040 Idle: no requests for 10 cycles -> no grants, bram_wr=0 throughout, bram_addr unchanged.

Source files
------------

// File: rtl/map_bram_if.sv
// Bundle of the render read port, the game read/write port and the map BRAM
// port shared between map_bram_arbiter and whatever drives it.
interface map_bram_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 16
);
   logic              r_req;
   logic [ADDR_W-1:0] r_addr;
   logic              r_gnt;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;

   logic              g_req;
   logic              g_we;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_wdata;
   logic              g_gnt;
   logic [DATA_W-1:0] g_rdata;
   logic              g_rvalid;

   logic [ADDR_W-1:0] bram_addr;
   logic              bram_wr;
   logic [DATA_W-1:0] bram_dwrite;
   logic [DATA_W-1:0] bram_data;

   modport slave (
      input  r_req, r_addr, g_req, g_we, g_addr, g_wdata, bram_data,
      output r_gnt, r_rdata, r_rvalid, g_gnt, g_rdata, g_rvalid,
             bram_addr, bram_wr, bram_dwrite
   );

   modport master (
      output r_req, r_addr, g_req, g_we, g_addr, g_wdata, bram_data,
      input  r_gnt, r_rdata, r_rvalid, g_gnt, g_rdata, g_rvalid,
             bram_addr, bram_wr, bram_dwrite
   );
endinterface

// File: rtl/map_bram_arbiter.sv
// Two-port arbiter onto a single map BRAM: render reads have priority, game
// accesses win after STARVE_LIMIT consecutive denied cycles (legal 1..15).
module map_bram_arbiter #(
   parameter int ADDR_W       = 19,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic      clk,
   input  logic      rst,
   map_bram_if.slave bus
);
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_RND  = 2'd1,
      OWN_GAME = 2'd2
   } owner_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic              r_gnt, g_gnt;
   logic [3:0]        starve_q, starve_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] dwr_q, dwr_d;
   owner_e            own_d;
   owner_e            own_pipe_q [2];
   logic [DATA_W-1:0] r_rdata_q, r_rdata_d, g_rdata_q, g_rdata_d;
   logic              r_rvalid_q, r_rvalid_d, g_rvalid_q, g_rvalid_d;

   // Grants are combinational and forced low during reset.
   always_comb begin
      g_gnt = 1'b0;
      r_gnt = 1'b0;
      if (!rst) begin
         g_gnt = bus.g_req && (!bus.r_req || (starve_q == LIMIT));
         r_gnt = bus.r_req && !g_gnt;
      end
   end

   always_comb begin
      starve_d = 4'd0;
      if (bus.g_req && !g_gnt)
         starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;

      addr_d = addr_q;
      wr_d   = 1'b0;
      dwr_d  = dwr_q;
      own_d  = OWN_NONE;
      if (g_gnt) begin
         addr_d = bus.g_addr;
         wr_d   = bus.g_we;
         dwr_d  = bus.g_wdata;
         own_d  = bus.g_we ? OWN_NONE : OWN_GAME;
      end else if (r_gnt) begin
         addr_d = bus.r_addr;
         own_d  = OWN_RND;
      end

      // Pipe slot 1 lines up with bram_data for the access issued two cycles ago.
      r_rdata_d  = r_rdata_q;
      g_rdata_d  = g_rdata_q;
      r_rvalid_d = 1'b0;
      g_rvalid_d = 1'b0;
      case (own_pipe_q[1])
         OWN_RND: begin
            r_rdata_d  = bus.bram_data;
            r_rvalid_d = 1'b1;
         end
         OWN_GAME: begin
            g_rdata_d  = bus.bram_data;
            g_rvalid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q      <= 4'd0;
         addr_q        <= '0;
         wr_q          <= 1'b0;
         dwr_q         <= '0;
         own_pipe_q[0] <= OWN_NONE;
         own_pipe_q[1] <= OWN_NONE;
         r_rdata_q     <= '0;
         g_rdata_q     <= '0;
         r_rvalid_q    <= 1'b0;
         g_rvalid_q    <= 1'b0;
      end else begin
         starve_q      <= starve_d;
         addr_q        <= addr_d;
         wr_q          <= wr_d;
         dwr_q         <= dwr_d;
         own_pipe_q[0] <= own_d;
         own_pipe_q[1] <= own_pipe_q[0];
         r_rdata_q     <= r_rdata_d;
         g_rdata_q     <= g_rdata_d;
         r_rvalid_q    <= r_rvalid_d;
         g_rvalid_q    <= g_rvalid_d;
      end
   end

   assign bus.r_gnt       = r_gnt;
   assign bus.g_gnt       = g_gnt;
   assign bus.r_rdata     = r_rdata_q;
   assign bus.r_rvalid    = r_rvalid_q;
   assign bus.g_rdata     = g_rdata_q;
   assign bus.g_rvalid    = g_rvalid_q;
   assign bus.bram_addr   = addr_q;
   assign bus.bram_wr     = wr_q;
   assign bus.bram_dwrite = dwr_q;
endmodule

// File: tb/tb_map_bram_arbiter.sv
// Scoreboard bench for map_bram_arbiter: a serial-order memory model predicts
// grants and read data; a separate monitor checks every rvalid against it.
module tb_map_bram_arbiter;
   localparam int AW = 19;
   localparam int DW = 16;
   localparam int SL = 4;

   typedef struct {
      logic [DW-1:0] d;
      int            due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   map_bram_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   map_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] init_val(input int a);
      if (a == 32'h107) return 16'h0023;
      return 16'(a * 37 + 5);
   endfunction

   // BRAM: one-cycle registered read, read-before-write.
   logic [DW-1:0] mem [int];
   function automatic logic [DW-1:0] mem_rd(input int a);
      return mem.exists(a) ? mem[a] : init_val(a);
   endfunction
   always @(posedge clk) begin
      bus.bram_data <= mem_rd(int'(bus.bram_addr));
      if (bus.bram_wr) mem[int'(bus.bram_addr)] = bus.bram_dwrite;
   end

   // Reference model: accesses take effect in grant order.
   logic [DW-1:0] ref_mem [int];
   function automatic logic [DW-1:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   exp_t          rq[$];
   exp_t          gq[$];
   int            denied = 0;
   logic          prev_rst = 1'b1;
   logic          exp_wr = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_wdata = '0;
   logic          exp_g, exp_r;

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("bram_wr", 32'(bus.bram_wr), 32'(exp_wr));
         chk("bram_addr", 32'(bus.bram_addr), 32'(exp_addr));
         if (exp_wr) chk("bram_dwrite", 32'(bus.bram_dwrite), 32'(exp_wdata));
         if (prev_rst) chk("rst_dwrite", 32'(bus.bram_dwrite), 32'd0);
         if (rst) begin
            chk("rst_r_gnt", 32'(bus.r_gnt), 32'd0);
            chk("rst_g_gnt", 32'(bus.g_gnt), 32'd0);
            exp_addr = '0;
            exp_wr   = 1'b0;
            denied   = 0;
         end else begin
            exp_g = bus.g_req && (!bus.r_req || denied == SL);
            exp_r = bus.r_req && !exp_g;
            chk("r_gnt", 32'(bus.r_gnt), 32'(exp_r));
            chk("g_gnt", 32'(bus.g_gnt), 32'(exp_g));
            exp_wr = 1'b0;
            if (exp_g) begin
               exp_addr = bus.g_addr;
               if (bus.g_we) begin
                  ref_mem[int'(bus.g_addr)] = bus.g_wdata;
                  exp_wr    = 1'b1;
                  exp_wdata = bus.g_wdata;
               end else begin
                  gq.push_back('{d: ref_rd(int'(bus.g_addr)), due: cyc + 3});
               end
            end else if (exp_r) begin
               exp_addr = bus.r_addr;
               rq.push_back('{d: ref_rd(int'(bus.r_addr)), due: cyc + 3});
            end
            if (bus.g_req && !exp_g) denied = (denied == SL) ? SL : denied + 1;
            else denied = 0;
         end
         prev_rst = rst;
      end
   end

   // Monitor: pops expectations whenever the DUT presents read data.
   logic [DW-1:0] last_r = '0;
   logic [DW-1:0] last_g = '0;
   exp_t          e;
   always @(negedge clk) begin
      if (cyc > 0) begin
         if (bus.r_rvalid) begin
            if (rq.size() == 0) chk("r_spurious_rvalid", 32'(bus.r_rvalid), 32'd0);
            else begin
               e = rq.pop_front();
               chk("r_latency", 32'(cyc), 32'(e.due));
               chk("r_rdata", 32'(bus.r_rdata), 32'(e.d));
               last_r = e.d;
            end
         end else chk("r_hold", 32'(bus.r_rdata), 32'(last_r));
         if (bus.g_rvalid) begin
            if (gq.size() == 0) chk("g_spurious_rvalid", 32'(bus.g_rvalid), 32'd0);
            else begin
               e = gq.pop_front();
               chk("g_latency", 32'(cyc), 32'(e.due));
               chk("g_rdata", 32'(bus.g_rdata), 32'(e.d));
               last_g = e.d;
            end
         end else chk("g_hold", 32'(bus.g_rdata), 32'(last_g));
         while (rq.size() > 0 && rq[0].due < cyc) begin
            chk("r_missing_rvalid", 32'(rq[0].due), 32'(cyc));
            void'(rq.pop_front());
         end
         while (gq.size() > 0 && gq[0].due < cyc) begin
            chk("g_missing_rvalid", 32'(gq[0].due), 32'(cyc));
            void'(gq.pop_front());
         end
         if (rst) begin
            rq.delete();
            gq.delete();
            last_r = '0;
            last_g = '0;
         end
      end
   end

   // Driver
   logic seen_r = 1'b0;
   logic seen_g = 1'b0;

   task automatic tick();
      @(negedge clk);
      seen_r = bus.r_gnt;
      seen_g = bus.g_gnt;
      @(posedge clk);
      #1;
   endtask

   task automatic game_op(input logic we, input int a, input logic [DW-1:0] d);
      bus.g_req   = 1'b1;
      bus.g_we    = we;
      bus.g_addr  = AW'(a);
      bus.g_wdata = d;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (seen_g) break;
      end
      chk("g_wait", 32'(seen_g), 32'd1);
      bus.g_req = 1'b0;
   endtask

   task automatic render_rd(input int a);
      bus.r_req  = 1'b1;
      bus.r_addr = AW'(a);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (seen_r) break;
      end
      chk("r_wait", 32'(seen_r), 32'd1);
      bus.r_req = 1'b0;
   endtask

   int g_win;

   initial begin
      bus.r_req = 1'b1; bus.r_addr = '0;
      bus.g_req = 1'b1; bus.g_we = 1'b0; bus.g_addr = '0; bus.g_wdata = '0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      bus.r_req = 1'b0;
      bus.g_req = 1'b0;
      tick();

      // Game read of a preloaded tile, then write-then-read of the same address
      game_op(1'b0, 32'h107, '0);
      repeat (4) tick();
      game_op(1'b1, 32'h107, 16'h0000);
      render_rd(32'h107);
      repeat (4) tick();

      // Starvation with render requesting every cycle
      bus.r_req = 1'b1; bus.r_addr = AW'(32'h40);
      bus.g_req = 1'b1; bus.g_we = 1'b0; bus.g_addr = AW'(32'h20);
      g_win = -1;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (seen_g && g_win < 0) begin
            g_win = i;
            bus.g_req = 1'b0;
         end
         if (seen_r) bus.r_addr = bus.r_addr + 1'b1;
      end
      chk("starve_g_cycle", 32'(g_win), 32'd4);
      bus.r_req = 1'b0;
      bus.g_req = 1'b0;
      repeat (4) tick();

      // Back-to-back render reads
      render_rd(32'h10);
      render_rd(32'h11);
      render_rd(32'h12);
      repeat (4) tick();

      // Reset with a game read in flight
      game_op(1'b0, 32'h55, '0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (5) tick();

      // Idle
      repeat (10) tick();

      // Random traffic on a small address window to force collisions
      for (int n = 0; n < 500; n++) begin
         if (!bus.r_req || seen_r || $urandom_range(9) == 0) begin
            bus.r_req  = 1'($urandom_range(1));
            bus.r_addr = AW'($urandom_range(15));
         end
         if (!bus.g_req || seen_g || $urandom_range(9) == 0) begin
            bus.g_req   = 1'($urandom_range(1));
            bus.g_we    = 1'($urandom_range(1));
            bus.g_addr  = AW'($urandom_range(15));
            bus.g_wdata = DW'($urandom);
         end
         rst = ($urandom_range(80) == 0);
         tick();
      end
      rst = 1'b0;
      bus.r_req = 1'b0;
      bus.g_req = 1'b0;
      repeat (8) tick();
      chk("r_drain", 32'(rq.size()), 32'd0);
      chk("g_drain", 32'(gq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
